// File: rtl/l0_skew_buffer_pkg.sv
// l0_skew_buffer_pkg: shared read-mode constants and lane/pointer width helpers
package l0_skew_buffer_pkg;

    localparam logic MODE_PARALLEL = 1'b0;
    localparam logic MODE_SKEW     = 1'b1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lane_lsb(input int lane, input int bw);
        return lane * bw;
    endfunction

endpackage

// File: rtl/l0_skew_buffer_if.sv
// l0_skew_buffer_if: write/read handshake and status bus of the skew buffer
interface l0_skew_buffer_if #(
    parameter int ROW = 8,
    parameter int BW  = 4
);

    logic              wr;
    logic [ROW*BW-1:0] in;
    logic              rd;
    logic              mode;
    logic [ROW*BW-1:0] out;
    logic [ROW-1:0]    o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_empty;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output wr, in, rd, mode,
        input  out, o_valid, o_full, o_ready, o_empty, o_overflow, o_underflow
    );

    modport slave (
        input  wr, in, rd, mode,
        output out, o_valid, o_full, o_ready, o_empty, o_overflow, o_underflow
    );

endinterface

// File: rtl/l0_lane_fifo.sv
// l0_lane_fifo: one lane FIFO with a registered head that only updates on a pop
module l0_lane_fifo
    import l0_skew_buffer_pkg::*;
#(
    parameter int BW    = 4,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [BW-1:0] din,
    output logic [BW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int AW = ptr_w(DEPTH);

    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // full/empty are pre-edge, so a push never rescues a pop on an empty lane
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // storage array, written at the tail; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    // pointers wrap naturally at DEPTH; head register holds between pops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) begin
                rptr <= rptr + AW'(1);
                dout <= mem[rptr];
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/l0_skew_buffer.sv
// l0_skew_buffer: ROW-lane activation buffer with parallel or diagonally skewed reads
module l0_skew_buffer
    import l0_skew_buffer_pkg::*;
#(
    parameter int ROW   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64
) (
    input logic clk,
    input logic reset,
    l0_skew_buffer_if.slave bus
);

    logic [ROW-1:0] rd_en;
    logic [ROW-1:0] empty;
    logic [ROW-1:0] full;
    logic           mode_q;
    logic           push;

    // lanes are written atomically so they never drift out of alignment
    assign push        = bus.wr && bus.o_ready;
    assign bus.o_full  = |full;
    assign bus.o_ready = ~bus.o_full;
    assign bus.o_empty = &empty;

    for (genvar i = 0; i < ROW; i++) begin : g_lane
        l0_lane_fifo #(.BW(BW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push),
            .pop   (rd_en[i]),
            .din   (bus.in[lane_lsb(i, BW) +: BW]),
            .dout  (bus.out[lane_lsb(i, BW) +: BW]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    // launch chain; mode only switches once the chain has fully drained
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en  <= '0;
            mode_q <= MODE_PARALLEL;
        end else begin
            rd_en <= (mode_q == MODE_SKEW) ? {rd_en[ROW-2:0], bus.rd} : {ROW{bus.rd}};
            if (rd_en == '0) mode_q <= bus.mode;
        end
    end

    // per-lane valid follows a real pop; error flags stick until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.o_valid     <= '0;
            bus.o_overflow  <= 1'b0;
            bus.o_underflow <= 1'b0;
        end else begin
            bus.o_valid <= rd_en & ~empty;
            if (bus.wr && bus.o_full) bus.o_overflow <= 1'b1;
            if (|(rd_en & empty)) bus.o_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_l0_skew_buffer.sv
// tb_l0_skew_buffer: directed and random stimulus against a queue-based lane model
module tb_l0_skew_buffer;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    int   errs   = 0;
    int   checks = 0;

    l0_skew_buffer_if #(.ROW(ROW), .BW(BW)) bus();

    l0_skew_buffer #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [BW-1:0]     q [ROW][$];
    logic [ROW*BW-1:0] m_out  = '0;
    logic [ROW-1:0]    m_val  = '0;
    logic [ROW-1:0]    m_rden = '0;
    logic [ROW-1:0]    m_nxt;
    logic              m_mode = 1'b0;
    logic              m_ovf  = 1'b0;
    logic              m_udf  = 1'b0;
    logic              m_fpre;

    function automatic logic model_full();
        for (int i = 0; i < ROW; i++) if (q[i].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_empty();
        for (int i = 0; i < ROW; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // reference: each lane is a queue; pops see pre-edge occupancy, then writes append
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            for (int i = 0; i < ROW; i++) q[i].delete();
            m_out  = '0;
            m_val  = '0;
            m_rden = '0;
            m_mode = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            m_fpre = model_full();
            for (int i = 0; i < ROW; i++) begin
                m_val[i] = 1'b0;
                if (m_rden[i]) begin
                    if (q[i].size() != 0) begin
                        m_out[i*BW +: BW] = q[i].pop_front();
                        m_val[i] = 1'b1;
                    end else begin
                        m_udf = 1'b1;
                    end
                end
            end
            if (bus.wr) begin
                if (m_fpre) m_ovf = 1'b1;
                else for (int i = 0; i < ROW; i++) q[i].push_back(bus.in[i*BW +: BW]);
            end
            m_nxt = m_mode ? {m_rden[ROW-2:0], bus.rd} : {ROW{bus.rd}};
            if (m_rden == '0) m_mode = bus.mode;
            m_rden = m_nxt;
        end
    end

    // compare every cycle, just after the falling edge
    initial forever begin
        @(negedge clk);
        #1;
        chk("out", bus.out, m_out);
        chk("o_valid", bus.o_valid, m_val);
        chk("o_full", bus.o_full, model_full());
        chk("o_ready", bus.o_ready, !model_full());
        chk("o_empty", bus.o_empty, model_empty());
        chk("o_overflow", bus.o_overflow, m_ovf);
        chk("o_underflow", bus.o_underflow, m_udf);
    end

    logic [7:0]        exp3 [13] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3C,
                                     8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    logic [7:0]        exp6 [12] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C,
                                     8'h38, 8'h70, 8'hE0, 8'hC0, 8'h80, 8'h00};
    logic [7:0]        exp2 [5]  = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    logic [ROW*BW-1:0] w;

    initial begin
        reset = 1'b1;
        bus.wr = 1'b0;
        bus.in = '0;
        bus.rd = 1'b0;
        bus.mode = 1'b0;
        repeat (2) tick();
        chk("rst_empty", bus.o_empty, 1);
        chk("rst_full", bus.o_full, 0);
        chk("rst_ready", bus.o_ready, 1);
        reset = 1'b0;
        tick();

        bus.wr = 1'b1;
        repeat (10) begin
            bus.in = $urandom;
            tick();
        end
        bus.wr = 1'b0;
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("midrst_empty", bus.o_empty, 1);
        chk("midrst_out", bus.out, 0);
        chk("midrst_valid", bus.o_valid, 0);
        chk("midrst_flags", {bus.o_overflow, bus.o_underflow}, 0);
        tick();
        chk("midrst_hold_empty", bus.o_empty, 1);
        reset = 1'b0;
        tick();

        bus.wr = 1'b1;
        bus.in = 32'h76543210;
        repeat (3) tick();
        bus.wr = 1'b0;
        bus.rd = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 2) bus.rd = 1'b0;
            chk("par_valid", bus.o_valid, exp2[k]);
            if (exp2[k] != 0) chk("par_out", bus.out, 32'h76543210);
        end

        bus.mode = 1'b1;
        repeat (2) tick();
        bus.wr = 1'b1;
        repeat (4) begin
            bus.in = $urandom;
            tick();
        end
        bus.wr = 1'b0;
        bus.rd = 1'b1;
        for (int k = 0; k < 13; k++) begin
            tick();
            if (k == 3) bus.rd = 1'b0;
            chk("skew_valid", bus.o_valid, exp3[k]);
        end
        chk("skew_drained", bus.o_empty, 1);

        bus.mode = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.wr = 1'b1;
        repeat (DEPTH) begin
            bus.in = $urandom;
            tick();
        end
        chk("full_flag", bus.o_full, 1);
        chk("full_ready", bus.o_ready, 0);
        tick();
        bus.wr = 1'b0;
        chk("overflow", bus.o_overflow, 1);
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        tick();
        chk("unfull", bus.o_full, 0);
        bus.wr = 1'b1;
        tick();
        bus.wr = 1'b0;
        chk("refill", bus.o_full, 1);
        bus.rd = 1'b1;
        repeat (DEPTH) tick();
        bus.rd = 1'b0;
        repeat (3) tick();
        chk("drain_empty", bus.o_empty, 1);
        chk("drain_no_udf", bus.o_underflow, 0);

        bus.mode = 1'b1;
        repeat (2) tick();
        bus.wr = 1'b1;
        repeat (2) begin
            bus.in = $urandom;
            tick();
        end
        bus.wr = 1'b0;
        bus.rd = 1'b1;
        repeat (4) tick();
        bus.rd = 1'b0;
        repeat (12) tick();
        chk("underflow", bus.o_underflow, 1);
        chk("udf_empty", bus.o_empty, 1);
        w = $urandom;
        bus.wr = 1'b1;
        bus.in = w;
        tick();
        bus.wr = 1'b0;
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        repeat (12) tick();
        chk("udf_noskip", bus.out, w);

        bus.wr = 1'b1;
        repeat (8) begin
            bus.in = $urandom;
            tick();
        end
        bus.wr = 1'b0;
        bus.rd = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 1) bus.mode = 1'b0;
            if (k == 2) bus.rd = 1'b0;
            chk("switch_valid", bus.o_valid, exp6[k]);
        end
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        tick();
        chk("switch_parallel", bus.o_valid, 8'hFF);

        for (int p = 0; p < 2; p++) begin
            repeat (700) begin
                tick();
                reset = ($urandom_range(0, 199) == 0);
                bus.wr = p == 0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                bus.rd = p == 0 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                bus.in = $urandom;
                if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
            end
        end
        reset = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        repeat (3) tick();
        #2;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
